// File: rtl/neuron_accumulator_pkg.sv
// Shared accelerator definitions: FSM state encoding, saturating add and requantize helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package neuron_accumulator_pkg;

   // Working width for the helper functions; callers sign-extend into it and truncate back.
   localparam int MAX_W = 64;

   typedef logic signed [MAX_W-1:0] wide_t;

   // Neuron job FSM encoding (kept as plain constants for legacy tooling compatibility).
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE   = 2'd0;
   localparam state_t ST_ACCUM  = 2'd1;
   localparam state_t ST_FINISH = 2'd2;
   localparam state_t ST_OUT    = 2'd3;

   // Signed add clipped to a 'width'-bit two's-complement range; clip flags saturation.
   // Operands must already fit in 'width' bits, so the MAX_W sum itself never overflows.
   function automatic wide_t sat_add(input wide_t a, input wide_t b, input int width,
                                     output logic clip);
      wide_t sum;
      wide_t hi;
      wide_t lo;
      sum  = a + b;
      hi   = (64'sd1 <<< (width - 1)) - 64'sd1;
      lo   = -(64'sd1 <<< (width - 1));
      clip = 1'b0;
      if (sum > hi) begin
         sum  = hi;
         clip = 1'b1;
      end else if (sum < lo) begin
         sum  = lo;
         clip = 1'b1;
      end
      return sum;
   endfunction

   // Round half toward +inf, arithmetic right shift, then clip to an 'out_width'-bit signed range.
   // Adding the half-LSB before an arithmetic shift gives floor(x + 0.5) for both signs.
   function automatic wide_t round_shift_clip(input wide_t a, input int frac_shift,
                                              input int out_width, output logic clip);
      wide_t r;
      wide_t hi;
      wide_t lo;
      r    = (a + (64'sd1 <<< (frac_shift - 1))) >>> frac_shift;
      hi   = (64'sd1 <<< (out_width - 1)) - 64'sd1;
      lo   = -(64'sd1 <<< (out_width - 1));
      clip = 1'b0;
      if (r > hi) begin
         r    = hi;
         clip = 1'b1;
      end else if (r < lo) begin
         r    = lo;
         clip = 1'b1;
      end
      return r;
   endfunction

endpackage

// File: rtl/neuron_accumulator_requant_round_sat.sv
// Combinational requantizer: round, arithmetic shift and clip a wide accumulator to OUT_WIDTH.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the parent registers the result.
module requant_round_sat
   import neuron_accumulator_pkg::*;
#(
   parameter int ACC_WIDTH  = 24,
   parameter int OUT_WIDTH  = 8,
   parameter int FRAC_SHIFT = 7
) (
   input  logic signed [ACC_WIDTH-1:0] acc,
   output logic signed [OUT_WIDTH-1:0] res,
   output logic                        clip
);

   wide_t r_wide;
   logic  unused_r_hi;

   // Evaluate the shared round/shift/clip helper on the sign-extended accumulator.
   always_comb begin
      r_wide = round_shift_clip(wide_t'(acc), FRAC_SHIFT, OUT_WIDTH, clip);
      res    = r_wide[OUT_WIDTH-1:0];
   end

   // Upper bits are pure sign extension after the clip and carry no information.
   assign unused_r_hi = ^r_wide[MAX_W-1:OUT_WIDTH];

endmodule

// File: rtl/neuron_accumulator.sv
// Per-neuron accumulator: bias + sum of products, then round/shift/saturate to activation width.
// Latency: last product accepted -> one FINISH cycle -> out_valid on the following edge.
// Backpressure: prod_ready only in ACCUM; result held in OUT until out_ready handshake.
module neuron_accumulator
   import neuron_accumulator_pkg::*;
#(
   parameter int PROD_WIDTH = 16,
   parameter int ACC_WIDTH  = 24,
   parameter int OUT_WIDTH  = 8,
   parameter int FRAC_SHIFT = 7,
   parameter int CNT_WIDTH  = 9
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic        [CNT_WIDTH-1:0]  num_terms,
   input  logic signed [ACC_WIDTH-1:0]  bias,
   input  logic                         prod_valid,
   output logic                         prod_ready,
   input  logic signed [PROD_WIDTH-1:0] prod_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic signed [OUT_WIDTH-1:0]  out_data,
   output logic                         busy,
   output logic                         sat
);

   state_t                      state;
   logic signed [ACC_WIDTH-1:0] acc;
   logic        [CNT_WIDTH-1:0] cnt;
   logic        [CNT_WIDTH-1:0] terms;

   wide_t                       add_wide;
   logic                        add_clip;
   logic signed [ACC_WIDTH-1:0] acc_sum;
   logic                        unused_add_hi;

   logic signed [OUT_WIDTH-1:0] rq_res;
   logic                        rq_clip;

   logic                        prod_fire;
   logic                        last_beat;

   // Saturating accumulate of the incoming product into the running sum.
   always_comb begin
      add_wide = sat_add(wide_t'(acc), wide_t'(prod_data), ACC_WIDTH, add_clip);
      acc_sum  = add_wide[ACC_WIDTH-1:0];
   end

   // Bits above ACC_WIDTH only repeat the sign after clipping.
   assign unused_add_hi = ^add_wide[MAX_W-1:ACC_WIDTH];

   // Requantizer sees the registered accumulator; its result is captured in FINISH.
   requant_round_sat #(
      .ACC_WIDTH  (ACC_WIDTH),
      .OUT_WIDTH  (OUT_WIDTH),
      .FRAC_SHIFT (FRAC_SHIFT)
   ) u_requant (
      .acc  (acc),
      .res  (rq_res),
      .clip (rq_clip)
   );

   // Handshake flags derive only from registered state, so no input feeds an output combinationally.
   always_comb begin
      prod_ready = (state == ST_ACCUM);
      busy       = (state != ST_IDLE);
      prod_fire  = prod_ready && prod_valid;
      last_beat  = (cnt == (terms - 1'b1));
   end

   // Job FSM plus accumulator, beat counter, sticky saturation flag and output register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         acc       <= '0;
         cnt       <= '0;
         terms     <= '0;
         sat       <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  terms <= num_terms;
                  acc   <= bias;
                  cnt   <= '0;
                  sat   <= 1'b0;
                  state <= (num_terms == '0) ? ST_FINISH : ST_ACCUM;
               end
            end
            ST_ACCUM: begin
               if (prod_fire) begin
                  acc <= acc_sum;
                  sat <= sat | add_clip;
                  cnt <= cnt + 1'b1;
                  if (last_beat) begin
                     state <= ST_FINISH;
                  end
               end
            end
            ST_FINISH: begin
               out_data  <= rq_res;
               sat       <= sat | rq_clip;
               out_valid <= 1'b1;
               state     <= ST_OUT;
            end
            default: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_neuron_accumulator.sv
// Directed self-checking bench for neuron_accumulator at default parameters.
// Latency: checks last-beat -> FINISH -> out_valid timing and the handshake return to IDLE.
// Backpressure: exercises product gaps, held out_ready and ignored start pulses.
module tb_neuron_accumulator;

   logic               clk;
   logic               rst_n;
   logic               start;
   logic [8:0]         num_terms;
   logic signed [23:0] bias;
   logic               prod_valid;
   logic               prod_ready;
   logic signed [15:0] prod_data;
   logic               out_valid;
   logic               out_ready;
   logic signed [7:0]  out_data;
   logic               busy;
   logic               sat;

   int checks = 0;
   int errors = 0;

   neuron_accumulator dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .num_terms  (num_terms),
      .bias       (bias),
      .prod_valid (prod_valid),
      .prod_ready (prod_ready),
      .prod_data  (prod_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .busy       (busy),
      .sat        (sat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Present start for one edge; returns at the negedge after it was sampled.
   task automatic start_job(input logic [8:0] nt, input logic signed [23:0] b);
      start     = 1'b1;
      num_terms = nt;
      bias      = b;
      @(negedge clk);
      start     = 1'b0;
      num_terms = '0;
      bias      = '0;
   endtask

   // Offer one product and hold it until accepted (bounded).
   task automatic send_beat(input logic signed [15:0] p);
      int n;
      n          = 0;
      prod_valid = 1'b1;
      prod_data  = p;
      while (!prod_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("beat_ready", prod_ready, 1);
      @(negedge clk);
      prod_valid = 1'b0;
      prod_data  = '0;
   endtask

   task automatic wait_out(input string tag);
      int n;
      n = 0;
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk(tag, out_valid, 1);
   endtask

   // Wait for the result, check it, complete the handshake and confirm return to IDLE.
   task automatic finish_job(input string tag, input logic signed [7:0] exp_d, input logic exp_s);
      wait_out({tag, "_valid"});
      chk({tag, "_data"}, out_data, exp_d);
      chk({tag, "_sat"}, sat, exp_s);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, "_drop"}, out_valid, 0);
      chk({tag, "_idle"}, busy, 0);
   endtask

   logic signed [23:0] rnd_bias [4];
   logic signed [7:0]  rnd_exp  [4];

   initial begin
      rst_n      = 1'b0;
      start      = 1'b0;
      num_terms  = '0;
      bias       = '0;
      prod_valid = 1'b0;
      prod_data  = '0;
      out_ready  = 1'b0;
      rnd_bias   = '{24'sd64, 24'sd63, -24'sd64, -24'sd65};
      rnd_exp    = '{8'sd1, 8'sd0, 8'sd0, -8'sd1};

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_prod_ready", prod_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_sat", sat, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Basic job: 0 + 128 + 256 - 128 = 256 -> (256+64)>>>7 = 2
      start_job(9'd3, 24'sd0);
      chk("basic_busy", busy, 1);
      send_beat(16'sd128);
      send_beat(16'sd256);
      send_beat(-16'sd128);
      chk("basic_finish_no_valid", out_valid, 0);
      chk("basic_finish_busy", busy, 1);
      @(negedge clk);
      chk("basic_latency", out_valid, 1);
      finish_job("basic", 8'sd2, 1'b0);

      // Rounding boundaries with zero-term jobs
      for (int i = 0; i < 4; i++) begin
         start_job(9'd0, rnd_bias[i]);
         finish_job("round", rnd_exp[i], 1'b0);
      end

      // Output saturation both directions
      start_job(9'd1, 24'sd0);
      send_beat(16'sd32767);
      finish_job("osat_pos", 8'sd127, 1'b1);
      start_job(9'd1, 24'sd0);
      send_beat(-16'sd32768);
      finish_job("osat_neg", -8'sd128, 1'b1);

      // Accumulator saturation: 8388607 + 1 clips, then output clips
      start_job(9'd1, 24'sd8388607);
      send_beat(16'sd1);
      finish_job("asat", 8'sd127, 1'b1);

      // Valid gaps: 640 + (gap) + 640 = 1280 -> (1280+64)>>>7 = 10
      start_job(9'd2, 24'sd0);
      prod_valid = 1'b1;
      prod_data  = 16'sd640;
      @(negedge clk);
      prod_valid = 1'b0;
      prod_data  = 16'sd9999;
      @(negedge clk);
      chk("gap_still_accum", prod_ready, 1);
      prod_valid = 1'b1;
      prod_data  = 16'sd640;
      @(negedge clk);
      prod_valid = 1'b0;
      prod_data  = '0;
      wait_out("gap_valid");
      chk("gap_data", out_data, 10);

      // Hold off the result: output stable, no product accepted, start ignored
      for (int i = 0; i < 5; i++) begin
         start      = 1'b1;
         num_terms  = 9'd0;
         bias       = 24'sd12800;
         prod_valid = 1'b1;
         prod_data  = 16'sd5;
         @(negedge clk);
         chk("hold_valid", out_valid, 1);
         chk("hold_data", out_data, 10);
         chk("hold_prod_ready", prod_ready, 0);
      end
      start      = 1'b0;
      num_terms  = '0;
      bias       = '0;
      prod_valid = 1'b0;
      prod_data  = '0;
      out_ready  = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("release_drop", out_valid, 0);
      chk("release_idle", busy, 0);
      chk("release_sat", sat, 0);
      @(negedge clk);
      chk("release_stays_idle", busy, 0);
      chk("release_data_held", out_data, 10);

      // Reset mid-ACCUM after 2 of 4 beats
      start_job(9'd4, 24'sd0);
      send_beat(16'sd1000);
      send_beat(16'sd1000);
      chk("pre_rst_busy", busy, 1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("midrst_busy", busy, 0);
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_prod_ready", prod_ready, 0);
      @(negedge clk);
      chk("midrst_no_result", out_valid, 0);

      // Fresh job after reset: (384+64)>>>7 = 3
      start_job(9'd0, 24'sd384);
      finish_job("post_rst", 8'sd3, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
